// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
// Shared definitions for the enigma output path.
//   - Lampboard letter-code constants (CODE_MAX, CODE_IDLE)
//   - ASCII constants for letters and line/group separators
//   - Formatter state enum
//   - letter_ascii() helper mapping a letter code to its ASCII byte
// -----------------------------------------------------------------------------
package enigma_pkg;

   localparam logic [4:0] CODE_MAX  = 5'd25;
   localparam logic [4:0] CODE_IDLE = 5'd31;

   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LETTER,
      ST_SPACE,
      ST_CR,
      ST_LF
   } fmt_state_t;

   // Letter codes 0..25 map straight onto 'A'..'Z'.
   function automatic logic [7:0] letter_ascii(input logic [4:0] code);
      return ASCII_A + {3'b000, code};
   endfunction

endpackage

// File: rtl/cipher_output_formatter_if.sv
// -----------------------------------------------------------------------------
// cipher_output_formatter_if
// Handshake bundle between the enigma core, the formatter and the UART side.
//   in_code/in_valid/in_ready : letter codes from the core
//   flush                     : single-cycle request to terminate the line
//   out_byte/out_valid/out_ready : ASCII byte stream toward the UART
// Modports:
//   master : the environment (core + UART) driving codes and consuming bytes
//   slave  : the formatter itself
// -----------------------------------------------------------------------------
interface cipher_output_formatter_if;

   logic [4:0] in_code;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_code, in_valid, flush, out_ready,
      input  in_ready, out_byte, out_valid
   );

   modport slave (
      input  in_code, in_valid, flush, out_ready,
      output in_ready, out_byte, out_valid
   );

endinterface

// File: rtl/cipher_output_formatter_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
// Synchronous FIFO for 5-bit letter codes, DEPTH entries (power of two).
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   push, wr_data : write request and data (ignored when full)
//   pop, rd_data  : read request (ignored when empty); rd_data shows the head
//   full, empty, count : occupancy status
// -----------------------------------------------------------------------------
module code_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !rst;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array carries no reset; stale entries are never visible because
   // the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
   // push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cipher_output_formatter.sv
// -----------------------------------------------------------------------------
// cipher_output_formatter
// Turns the enigma lampboard letter stream into classic five-letter cipher
// groups: letters are buffered, emitted as ASCII, separated by a space after
// every GROUP_LEN letters and by CR LF after every GROUPS_PER_LINE groups.
// A flush request terminates a partial line with CR LF.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   bus        : slave side of cipher_output_formatter_if (codes in, bytes out)
//   fifo_count : number of letter codes currently buffered
//   bad_code   : sticky flag, a code in 26..30 was received
// -----------------------------------------------------------------------------
module cipher_output_formatter
   import enigma_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int GROUP_LEN       = 5,
   parameter int GROUPS_PER_LINE = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   cipher_output_formatter_if.slave    bus,
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic                        bad_code
);

   localparam int LW = $clog2(GROUP_LEN + 1);
   localparam int GW = $clog2(GROUPS_PER_LINE + 1);
   localparam logic [LW-1:0] LAST_LETTER = LW'(GROUP_LEN - 1);
   localparam logic [GW-1:0] LAST_GROUP  = GW'(GROUPS_PER_LINE - 1);

   fmt_state_t    state;
   logic [LW-1:0] letter_cnt;
   logic [GW-1:0] group_cnt;
   logic          sep_due;
   logic          line_due;
   logic          flush_pending;
   logic [7:0]    out_byte_q;
   logic          out_valid_q;

   logic          fifo_full;
   logic          fifo_empty;
   logic [4:0]    fifo_rd_data;
   logic          in_ready_int;
   logic          accept;
   logic          push;
   logic          pop;
   logic          load_en;
   logic          sep_pending;
   logic          code_bad;

   assign in_ready_int  = !fifo_full && !rst;
   assign bus.in_ready  = in_ready_int;
   assign bus.out_byte  = out_byte_q;
   assign bus.out_valid = out_valid_q;

   assign accept   = bus.in_valid && in_ready_int;
   assign push     = accept && (bus.in_code <= CODE_MAX);
   assign code_bad = accept && (bus.in_code > CODE_MAX) && (bus.in_code != CODE_IDLE);

   // The output register may only change when it is empty or being consumed.
   // A pending separator (LF after CR, or a group/line break) outranks letters,
   // so the FIFO is popped only when no separator is owed.
   assign load_en     = !out_valid_q || bus.out_ready;
   assign sep_pending = (state == ST_CR) || sep_due;
   assign pop         = load_en && !sep_pending && !fifo_empty;

   code_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (5)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (bus.in_code),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Formatter FSM and output register.
   // sep_due marks that a group just completed; line_due additionally marks
   // that it completed the line, so the owed separator is CR (then LF via the
   // ST_CR state) instead of a space. The group counters are cleared at the
   // moment the line-completing letter loads, so after CR LF both read zero.
   // A flush is only serviced once the FIFO is drained and no separator is
   // owed; with both counters at zero it is simply dropped. The flush input is
   // sampled last so a request arriving on the servicing edge is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         letter_cnt    <= '0;
         group_cnt     <= '0;
         sep_due       <= 1'b0;
         line_due      <= 1'b0;
         flush_pending <= 1'b0;
         out_byte_q    <= 8'h00;
         out_valid_q   <= 1'b0;
         bad_code      <= 1'b0;
      end else begin
         if (code_bad) begin
            bad_code <= 1'b1;
         end

         if (load_en) begin
            if (state == ST_CR) begin
               out_byte_q  <= ASCII_LF;
               out_valid_q <= 1'b1;
               state       <= ST_LF;
            end else if (sep_due) begin
               sep_due     <= 1'b0;
               out_valid_q <= 1'b1;
               if (line_due) begin
                  line_due   <= 1'b0;
                  out_byte_q <= ASCII_CR;
                  state      <= ST_CR;
               end else begin
                  out_byte_q <= ASCII_SPACE;
                  state      <= ST_SPACE;
               end
            end else if (!fifo_empty) begin
               out_byte_q  <= letter_ascii(fifo_rd_data);
               out_valid_q <= 1'b1;
               state       <= ST_LETTER;
               if (letter_cnt == LAST_LETTER) begin
                  letter_cnt <= '0;
                  sep_due    <= 1'b1;
                  if (group_cnt == LAST_GROUP) begin
                     group_cnt <= '0;
                     line_due  <= 1'b1;
                  end else begin
                     group_cnt <= group_cnt + GW'(1);
                  end
               end else begin
                  letter_cnt <= letter_cnt + LW'(1);
               end
            end else if (flush_pending) begin
               flush_pending <= 1'b0;
               if ((letter_cnt != '0) || (group_cnt != '0)) begin
                  out_byte_q  <= ASCII_CR;
                  out_valid_q <= 1'b1;
                  state       <= ST_CR;
                  letter_cnt  <= '0;
                  group_cnt   <= '0;
               end else begin
                  out_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end else begin
               out_valid_q <= 1'b0;
               state       <= ST_IDLE;
            end
         end

         if (bus.flush) begin
            flush_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cipher_output_formatter.sv
// -----------------------------------------------------------------------------
// tb_cipher_output_formatter
// Directed self-checking bench for cipher_output_formatter (defaults 16/5/5).
// Inputs change 1 time unit after the rising edge; outputs and the byte
// monitor sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_cipher_output_formatter;

   logic       clk;
   logic       rst;
   logic [4:0] fifo_count;
   logic       bad_code;

   int compared;
   int mismatched;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   cipher_output_formatter_if bus();

   cipher_output_formatter #(
      .DEPTH           (16),
      .GROUP_LEN       (5),
      .GROUPS_PER_LINE (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fifo_count (fifo_count),
      .bad_code   (bad_code)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte monitor: a transfer happens on the next rising edge whenever
   // out_valid and out_ready are both high at the falling edge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         rx_q.push_back(bus.out_byte);
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      rx_q.delete();
   endtask

   // Offers one code and holds it until accepted, with a cycle budget.
   task automatic send(input logic [4:0] c);
      bit acc;
      bit got;
      got          = 1'b0;
      bus.in_code  = c;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            got = 1'b1;
            break;
         end
      end
      bus.in_valid = 1'b0;
      if (!got) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL send_timeout: code %0d got no in_ready, expected acceptance", c);
      end
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
   endtask

   // Waits for n received bytes (bounded) and then a few more cycles so that
   // any spurious extra byte also lands in the queue.
   task automatic wait_bytes(input int n);
      for (int i = 0; i < 600 && rx_q.size() < n; i++) begin
         @(posedge clk);
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_code     = 5'd0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if (bus.in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_in_ready_during_rst: got %b expected 0", bus.in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      compared++;
      if (bus.out_byte !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_out_byte: got %h expected 00", bus.out_byte);
      end
      compared++;
      if (fifo_count !== 5'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_fifo_count: got %0d expected 0", fifo_count);
      end
      compared++;
      if (bad_code !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_bad_code: got %b expected 0", bad_code);
      end
      compared++;
      if (bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_in_ready_after: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_group_space();
      logic [7:0] got;
      do_reset();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 5; c++) send(5'(c));
      wait_bytes(6);
      exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20};
      compared++;
      if (rx_q.size() != exp_q.size()) begin
         mismatched++;
         $display("[TB] FAIL group_space_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         compared++;
         if (got !== exp_q[i]) begin
            mismatched++;
            $display("[TB] FAIL group_space_byte%0d: got %h expected %h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_line_break();
      logic [7:0] got;
      do_reset();
      bus.out_ready = 1'b1;
      exp_q.delete();
      for (int g = 0; g < 5; g++) begin
         for (int l = 0; l < 5; l++) exp_q.push_back(8'h41 + 8'(g * 5 + l));
         if (g < 4) exp_q.push_back(8'h20);
         else begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
         end
      end
      for (int c = 0; c < 25; c++) send(5'(c));
      wait_bytes(exp_q.size());
      compared++;
      if (rx_q.size() != exp_q.size()) begin
         mismatched++;
         $display("[TB] FAIL line_break_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         compared++;
         if (got !== exp_q[i]) begin
            mismatched++;
            $display("[TB] FAIL line_break_byte%0d: got %h expected %h", i, got, exp_q[i]);
         end
      end
      // Counters are back at zero, so a flush must produce nothing.
      rx_q.delete();
      pulse_flush();
      repeat (15) @(posedge clk);
      #1;
      compared++;
      if (rx_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL line_break_flush_after_line: got %0d bytes expected 0", rx_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] got;
      do_reset();
      bus.out_ready = 1'b0;
      // First code moves into the output register, the next 16 fill the FIFO.
      for (int c = 0; c < 17; c++) send(5'(c));
      @(negedge clk);
      compared++;
      if (fifo_count !== 5'd16) begin
         mismatched++;
         $display("[TB] FAIL backpressure_fifo_count: got %0d expected 16", fifo_count);
      end
      compared++;
      if (bus.in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL backpressure_in_ready: got %b expected 0", bus.in_ready);
      end
      compared++;
      if (bus.out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL backpressure_out_valid: got %b expected 1", bus.out_valid);
      end
      @(posedge clk); #1;
      bus.in_code  = 5'd17;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         compared++;
         if (bus.out_byte !== 8'h41 || fifo_count !== 5'd16) begin
            mismatched++;
            $display("[TB] FAIL backpressure_stall%0d: got byte %h count %0d expected byte 41 count 16", k, bus.out_byte, fifo_count);
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rx_q.delete();
      bus.out_ready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 17; i++) begin
         exp_q.push_back(8'h41 + 8'(i));
         if (i % 5 == 4) exp_q.push_back(8'h20);
      end
      wait_bytes(exp_q.size());
      compared++;
      if (rx_q.size() != exp_q.size()) begin
         mismatched++;
         $display("[TB] FAIL backpressure_drain_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         compared++;
         if (got !== exp_q[i]) begin
            mismatched++;
            $display("[TB] FAIL backpressure_byte%0d: got %h expected %h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_bad_code();
      logic [7:0] got;
      do_reset();
      bus.out_ready = 1'b1;
      send(5'd31);
      send(5'd27);
      send(5'd2);
      wait_bytes(1);
      compared++;
      if (rx_q.size() != 1) begin
         mismatched++;
         $display("[TB] FAIL bad_code_count: got %0d bytes expected 1", rx_q.size());
      end
      got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
      compared++;
      if (got !== 8'h43) begin
         mismatched++;
         $display("[TB] FAIL bad_code_byte: got %h expected 43", got);
      end
      compared++;
      if (bad_code !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL bad_code_flag: got %b expected 1", bad_code);
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      compared++;
      if (bad_code !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL bad_code_sticky: got %b expected 1", bad_code);
      end
   endtask

   task automatic test_flush();
      logic [7:0] got;
      do_reset();
      bus.out_ready = 1'b1;
      send(5'd0);
      send(5'd1);
      send(5'd2);
      pulse_flush();
      wait_bytes(5);
      exp_q = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
      compared++;
      if (rx_q.size() != exp_q.size()) begin
         mismatched++;
         $display("[TB] FAIL flush_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         compared++;
         if (got !== exp_q[i]) begin
            mismatched++;
            $display("[TB] FAIL flush_byte%0d: got %h expected %h", i, got, exp_q[i]);
         end
      end
      rx_q.delete();
      pulse_flush();
      repeat (15) @(posedge clk);
      #1;
      compared++;
      if (rx_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL flush_zero_counters: got %0d bytes expected 0", rx_q.size());
      end
      // Back-to-back flush requests terminate the line only once.
      rx_q.delete();
      send(5'd3);
      pulse_flush();
      pulse_flush();
      wait_bytes(3);
      exp_q = '{8'h44, 8'h0D, 8'h0A};
      compared++;
      if (rx_q.size() != exp_q.size()) begin
         mismatched++;
         $display("[TB] FAIL flush_double_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         compared++;
         if (got !== exp_q[i]) begin
            mismatched++;
            $display("[TB] FAIL flush_double_byte%0d: got %h expected %h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] got;
      do_reset();
      bus.out_ready = 1'b0;
      send(5'd28);
      for (int c = 0; c < 9; c++) send(5'(c));
      @(negedge clk);
      compared++;
      if (fifo_count !== 5'd8 || bus.out_valid !== 1'b1 || bad_code !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_before: got count %0d valid %b bad %b expected count 8 valid 1 bad 1", fifo_count, bus.out_valid, bad_code);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (fifo_count !== 5'd0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_fifo_count: got %0d expected 0", fifo_count);
      end
      compared++;
      if (bus.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_out_valid: got %b expected 0", bus.out_valid);
      end
      compared++;
      if (bad_code !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_bad_code: got %b expected 0", bad_code);
      end
      @(posedge clk); #1;
      rx_q.delete();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 5; c++) send(5'(c));
      wait_bytes(6);
      exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20};
      compared++;
      if (rx_q.size() != exp_q.size()) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_regroup_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         compared++;
         if (got !== exp_q[i]) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_regroup_byte%0d: got %h expected %h", i, got, exp_q[i]);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_group_space();
      test_line_break();
      test_backpressure();
      test_bad_code();
      test_flush();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
